// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
// Read-side master for the 80x60 one-bit whiteboard frame buffer. Generates
// 640x480@60 Hz VGA timing from the 50 MHz clock using a divide-by-2 pixel
// enable. It drives the buffer read coordinates (one cell = 8x8 screen pixels)
// and consumes the buffer's registered pixel bit one clk later. It outputs
// aligned 4-bit RGB and active-low syncs, with an optional red cursor cell.
//
// Ports:
//   clk           50 MHz system clock
//   reset_n       asynchronous active-low reset
//   pixel_black   buffer read data (1 = black), valid 1 clk after read_x/y
//   cursor_x/y    cursor cell column/row
//   cursor_enable paint the cursor cell red
//   read_x/y      buffer read coordinates (127/63 outside the visible area)
//   vga_r/g/b     4-bit colour
//   vga_hs/vs     active-low syncs
//   frame_start   one-clk pulse with the first output pixel of each frame
// ---------------------------------------------------------------------------
module vga_frame_reader #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CELL_SHIFT = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pixel_black,
    input  logic [6:0] cursor_x,
    input  logic [5:0] cursor_y,
    input  logic       cursor_enable,
    output logic [6:0] read_x,
    output logic [5:0] read_y,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       pix_en_r;
    logic [9:0] h_count_r;
    logic [9:0] v_count_r;

    // stage A: coordinates and per-pixel attributes, registered every clk
    logic       vis_s, hs_s, vs_s, hit_s, first_s;
    logic [6:0] rx_s;
    logic [5:0] ry_s;
    logic [6:0] read_x_r;
    logic [5:0] read_y_r;
    logic       vis_a_r, hs_a_r, vs_a_r, hit_a_r, first_a_r;

    // one-clk delay so the attributes line up with the buffer's registered data
    logic       vis_d_r, hs_d_r, vs_d_r, hit_d_r, first_d_r;

    // stage B: output registers
    logic [11:0] rgb_s;
    logic [11:0] rgb_r;
    logic        hs_r, vs_r, frame_start_r;

    // Pixel enable and the horizontal/vertical raster counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_en_r  <= 1'b0;
            h_count_r <= 10'd0;
            v_count_r <= 10'd0;
        end else begin
            pix_en_r <= ~pix_en_r;
            if (pix_en_r) begin
                if (h_count_r == H_LAST) begin
                    h_count_r <= 10'd0;
                    if (v_count_r == V_LAST) begin
                        v_count_r <= 10'd0;
                    end else begin
                        v_count_r <= v_count_r + 10'd1;
                    end
                end else begin
                    h_count_r <= h_count_r + 10'd1;
                end
            end else begin
                h_count_r <= h_count_r;
                v_count_r <= v_count_r;
            end
        end
    end

    // Decode of the current raster position into stage-A attributes.
    always_comb begin
        vis_s   = (h_count_r < H_VIS) && (v_count_r < V_VIS);
        hs_s    = ~((h_count_r >= HS_START) && (h_count_r < HS_END));
        vs_s    = ~((v_count_r >= VS_START) && (v_count_r < VS_END));
        first_s = (h_count_r == 10'd0) && (v_count_r == 10'd0);
        if (vis_s) begin
            rx_s = 7'(h_count_r >> CELL_SHIFT);
            ry_s = 6'(v_count_r >> CELL_SHIFT);
        end else begin
            rx_s = 7'd127;
            ry_s = 6'd63;
        end
        // out-of-range cursor values cannot equal a visible cell coordinate
        hit_s = cursor_enable && vis_s && (rx_s == cursor_x) && (ry_s == cursor_y);
    end

    // Stage-A registers plus the alignment delay, both updated every clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_x_r  <= 7'd127;
            read_y_r  <= 6'd63;
            vis_a_r   <= 1'b0;
            hs_a_r    <= 1'b1;
            vs_a_r    <= 1'b1;
            hit_a_r   <= 1'b0;
            first_a_r <= 1'b0;
            vis_d_r   <= 1'b0;
            hs_d_r    <= 1'b1;
            vs_d_r    <= 1'b1;
            hit_d_r   <= 1'b0;
            first_d_r <= 1'b0;
        end else begin
            read_x_r  <= rx_s;
            read_y_r  <= ry_s;
            vis_a_r   <= vis_s;
            hs_a_r    <= hs_s;
            vs_a_r    <= vs_s;
            hit_a_r   <= hit_s;
            first_a_r <= first_s;
            vis_d_r   <= vis_a_r;
            hs_d_r    <= hs_a_r;
            vs_d_r    <= vs_a_r;
            hit_d_r   <= hit_a_r;
            first_d_r <= first_a_r;
        end
    end

    // Colour selection: blanking, then cursor, then buffer data.
    always_comb begin
        rgb_s = 12'h000;
        if (!vis_d_r) begin
            rgb_s = 12'h000;
        end else if (hit_d_r) begin
            rgb_s = 12'hF00;
        end else if (pixel_black) begin
            rgb_s = 12'h000;
        end else begin
            rgb_s = 12'hFFF;
        end
    end

    // Stage-B output registers, loaded once per pixel period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_r         <= 12'h000;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            frame_start_r <= 1'b0;
        end else if (pix_en_r) begin
            rgb_r         <= rgb_s;
            hs_r          <= hs_d_r;
            vs_r          <= vs_d_r;
            frame_start_r <= first_d_r;
        end else begin
            rgb_r         <= rgb_r;
            hs_r          <= hs_r;
            vs_r          <= vs_r;
            frame_start_r <= 1'b0;
        end
    end

    assign read_x      = read_x_r;
    assign read_y      = read_y_r;
    assign vga_r       = rgb_r[11:8];
    assign vga_g       = rgb_r[7:4];
    assign vga_b       = rgb_r[3:0];
    assign vga_hs      = hs_r;
    assign vga_vs      = vs_r;
    assign frame_start = frame_start_r;

endmodule
